// File: rtl/time_text_writer.sv
// Writes the BCD time {min,sec} as "MM:SS" into the text RAM write port,
// one character per accepted write. The field is rewritten whenever the
// input differs from what was last latched for display, or on refresh.
module time_text_writer #(
  parameter int COLS = 80,
  parameter int ROW  = 0,
  parameter int COL  = 75
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  input  logic        refresh,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  // Address of the first character; truncation gives the modulo-4096 wrap.
  localparam int          BASE_I = ROW * COLS + COL;
  localparam logic [11:0] BASE   = BASE_I[11:0];

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_snap;
  logic [15:0] r_shown;

  state_t      w_state_nxt;
  logic [2:0]  w_idx_nxt;
  logic [15:0] w_snap_nxt;
  logic        w_start;
  logic        w_accept;

  // BCD nibble to ASCII; non-decimal nibbles render as '?'.
  function automatic logic [7:0] digit(input logic [3:0] nib);
    return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F;
  endfunction

  // Character at position idx of "MM:SS" for the latched value.
  function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [15:0] snap);
    case (idx)
      3'd0:    return digit(snap[15:12]);
      3'd1:    return digit(snap[11:8]);
      3'd2:    return 8'h3A;
      3'd3:    return digit(snap[7:4]);
      3'd4:    return digit(snap[3:0]);
      default: return 8'h00;
    endcase
  endfunction

  // Next-state decode; outputs are registered from these next values so the
  // first write appears one cycle after the triggering edge.
  always_comb begin
    w_start     = (r_state == IDLE) && (({min, sec} != r_shown) || refresh);
    w_accept    = (r_state == WRITE) && wr_ready;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    if (w_start) begin
      w_state_nxt = WRITE;
      w_idx_nxt   = 3'd0;
      w_snap_nxt  = {min, sec};
    end else if (w_accept) begin
      if (r_idx == 3'd4) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end else begin
        w_idx_nxt = r_idx + 3'd1;
      end
    end
  end

  // FSM state, latched values and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_snap  <= 16'h0000;
      r_shown <= 16'hFFFF;
      wr_en   <= 1'b0;
      wr_addr <= 12'd0;
      wr_data <= 8'd0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      if (w_start) r_shown <= {min, sec};
      wr_en   <= (w_state_nxt == WRITE);
      busy    <= (w_state_nxt == WRITE);
      wr_addr <= (w_state_nxt == WRITE) ? (BASE + {9'd0, w_idx_nxt}) : 12'd0;
      wr_data <= (w_state_nxt == WRITE) ? char_of(w_idx_nxt, w_snap_nxt) : 8'd0;
    end
  end

endmodule

// File: tb/tb_time_text_writer.sv
// Directed bench for time_text_writer: table of per-cycle vectors plus a
// hand-written reset-during-write sequence.
module tb_time_text_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  min, sec;
  logic        refresh, wr_ready;
  logic        wr_en, busy;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;

  time_text_writer dut (
    .clk(clk), .reset(reset), .min(min), .sec(sec), .refresh(refresh),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  sc;
    logic        rf;
    logic        rdy;
    logic        en;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [7:0] mn, input logic [7:0] sc,
                             input logic rf, input logic rdy,
                             input logic en, input int addr, input logic [7:0] data);
    vec_t t;
    t.mn = mn; t.sc = sc; t.rf = rf; t.rdy = rdy;
    t.en = en; t.addr = addr[11:0]; t.data = data; t.bsy = en;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [11:0] addr,
                         input logic [7:0] data, input logic bsy);
    chk({tag, " wr_en"},   {31'd0, wr_en}, {31'd0, en});
    chk({tag, " wr_addr"}, {20'd0, wr_addr}, {20'd0, addr});
    chk({tag, " wr_data"}, {24'd0, wr_data}, {24'd0, data});
    chk({tag, " busy"},    {31'd0, busy}, {31'd0, bsy});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Five accepted writes of one field, starting from IDLE with wr_ready high.
  task automatic field(input logic [7:0] mn, input logic [7:0] sc,
                       input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c3, input logic [7:0] c4);
    vecs.push_back(v(mn, sc, 0, 1, 1, 75, c0));
    vecs.push_back(v(mn, sc, 0, 1, 1, 76, c1));
    vecs.push_back(v(mn, sc, 0, 1, 1, 77, 8'h3A));
    vecs.push_back(v(mn, sc, 0, 1, 1, 78, c3));
    vecs.push_back(v(mn, sc, 0, 1, 1, 79, c4));
    vecs.push_back(v(mn, sc, 0, 1, 0, 0, 8'h00));
  endtask

  initial begin
    reset = 1'b1; min = 8'h12; sec = 8'h34; refresh = 1'b0; wr_ready = 1'b1;
    #2;
    chk_out("reset", 0, 12'd0, 8'h00, 0);

    // Release with 12:34 present: write starts on the first edge.
    field(8'h12, 8'h34, 8'h31, 8'h32, 8'h33, 8'h34);
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 0, 0, 8'h00));   // matches shown: stays idle

    // 09:59 then 10:00 on one edge: a single write of "10:00".
    field(8'h09, 8'h59, 8'h30, 8'h39, 8'h35, 8'h39);
    field(8'h10, 8'h00, 8'h31, 8'h30, 8'h30, 8'h30);
    vecs.push_back(v(8'h10, 8'h00, 0, 1, 0, 0, 8'h00));

    // wr_ready low for 3 cycles at idx2: 8 cycles of wr_en.
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 75, 8'h31));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 76, 8'h32));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 77, 8'h3A));
    vecs.push_back(v(8'h12, 8'h34, 0, 0, 1, 77, 8'h3A));
    vecs.push_back(v(8'h12, 8'h34, 0, 0, 1, 77, 8'h3A));
    vecs.push_back(v(8'h12, 8'h34, 0, 0, 1, 77, 8'h3A));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 78, 8'h33));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 79, 8'h34));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 0, 0, 8'h00));

    // Non-BCD nibble renders '?'; refresh during WRITE is dropped.
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 75, 8'h31));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 76, 8'h3F));
    vecs.push_back(v(8'h1A, 8'h34, 1, 1, 1, 77, 8'h3A));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 78, 8'h33));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 79, 8'h34));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 0, 0, 8'h00));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 0, 0, 8'h00));
    // Refresh pulse in IDLE with unchanged input: identical sequence.
    vecs.push_back(v(8'h1A, 8'h34, 1, 1, 1, 75, 8'h31));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 76, 8'h3F));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 77, 8'h3A));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 78, 8'h33));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 1, 79, 8'h34));
    vecs.push_back(v(8'h1A, 8'h34, 0, 1, 0, 0, 8'h00));

    // sec 34->35 while idx=1: finish "12:34", idle one cycle, then "12:35".
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 75, 8'h31));
    vecs.push_back(v(8'h12, 8'h34, 0, 1, 1, 76, 8'h32));
    vecs.push_back(v(8'h12, 8'h35, 0, 1, 1, 77, 8'h3A));
    vecs.push_back(v(8'h12, 8'h35, 0, 1, 1, 78, 8'h33));
    vecs.push_back(v(8'h12, 8'h35, 0, 1, 1, 79, 8'h34));
    vecs.push_back(v(8'h12, 8'h35, 0, 1, 0, 0, 8'h00));
    field(8'h12, 8'h35, 8'h31, 8'h32, 8'h33, 8'h35);
    vecs.push_back(v(8'h12, 8'h35, 0, 1, 0, 0, 8'h00));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      min = vecs[i].mn; sec = vecs[i].sc; refresh = vecs[i].rf; wr_ready = vecs[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].bsy);
    end

    // Reset pulsed while idx=2 aborts at once; full rewrite after release.
    min = 8'h12; sec = 8'h34; refresh = 1'b0; wr_ready = 1'b1;
    step(); chk_out("rst_seq0", 1, 12'd75, 8'h31, 1);
    step(); chk_out("rst_seq1", 1, 12'd76, 8'h32, 1);
    step(); chk_out("rst_seq2", 1, 12'd77, 8'h3A, 1);
    reset = 1'b1;
    #1;
    chk_out("rst_async", 0, 12'd0, 8'h00, 0);
    step(); chk_out("rst_held", 0, 12'd0, 8'h00, 0);
    reset = 1'b0;
    step(); chk_out("rst_re0", 1, 12'd75, 8'h31, 1);
    step(); chk_out("rst_re1", 1, 12'd76, 8'h32, 1);
    step(); chk_out("rst_re2", 1, 12'd77, 8'h3A, 1);
    step(); chk_out("rst_re3", 1, 12'd78, 8'h33, 1);
    step(); chk_out("rst_re4", 1, 12'd79, 8'h34, 1);
    step(); chk_out("rst_idle", 0, 12'd0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_text_writer.md
TIME_TEXT_WRITER -- requirements
Module: time_text_writer

Renders the BCD minutes/seconds produced by the time counter as the five characters "MM:SS" into the VGA text buffer write port.

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROW, default 0, text row of the display field.
REQ-003 Parameter COL, default 75, text column of the first character.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port min  input  8  BCD minutes: [7:4] tens, [3:0] ones.
REQ-007 Port sec  input  8  BCD seconds: [7:4] tens, [3:0] ones.
REQ-008 Port refresh  input  1  single-cycle request to rewrite the field even if unchanged.
REQ-009 Port wr_ready  input  1  text RAM accepts the current write this cycle.
REQ-010 Port wr_en  output  1  write request to text RAM.
REQ-011 Port wr_addr  output  12  character address, ROW*COLS + COL + index.
REQ-012 Port wr_data  output  8  ASCII character.
REQ-013 Port busy  output  1  high while a field write is in progress.

Function
REQ-014 The block SHALL hold a 16-bit register shown = last {min,sec} latched for display, and a 16-bit register snap = the value being written.
REQ-015 The FSM SHALL have two states, IDLE and WRITE, plus a 3-bit index idx (0..4).
REQ-016 In IDLE, when {min,sec} != shown or refresh=1 at a rising edge, the block SHALL load snap and shown with {min,sec}, clear idx, and enter WRITE.
REQ-017 First wr_en SHALL be asserted in the cycle immediately after the triggering edge (latency 1 cycle).
REQ-018 In WRITE, wr_en SHALL be 1 and wr_addr/wr_data SHALL be functions of idx and snap only (held stable while wr_ready=0).
REQ-019 Character map: idx0 = min tens, idx1 = min ones, idx2 = ':' (8'h3A), idx3 = sec tens, idx4 = sec ones.
REQ-020 Digit encoding: nibble 0..9 -> 8'h30 + nibble; nibble 10..15 -> '?' (8'h3F).
REQ-021 A write is accepted on a rising edge with wr_en=1 and wr_ready=1; the block SHALL then increment idx, or, if idx=4, return to IDLE.
REQ-022 A field write with wr_ready tied high SHALL take exactly 5 cycles of wr_en.
REQ-023 Changes of min/sec or refresh during WRITE SHALL NOT alter snap or the ongoing write; refresh in WRITE is dropped.
REQ-024 A change during WRITE SHALL be picked up in IDLE (shown mismatch) and start a new field write one cycle after return to IDLE.
REQ-025 In IDLE, wr_en SHALL be 0, and wr_addr/wr_data SHALL hold 0.
REQ-026 busy SHALL equal (state == WRITE).
REQ-027 wr_addr SHALL be computed modulo 2^12.

Reset
REQ-028 On reset assertion, the block SHALL asynchronously set state=IDLE, idx=0, snap=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, and shown=16'hFFFF.
REQ-029 Reset asserted mid-write SHALL abort the write immediately; no further characters are written.
REQ-030 After reset release, the first edge with valid BCD input SHALL start a field write, because shown=FFFF never matches valid BCD.

Verification
REQ-031 Reset release with min=8'h12, sec=8'h34, wr_ready=1 -> next 5 cycles: addr 75..79, data 31,32,3A,33,34 (hex); then IDLE, busy=0.
REQ-032 sec steps 8'h59->8'h00 and min 8'h09->8'h10 on the same edge -> one field write "10:00".
REQ-033 wr_ready low for 3 cycles at idx2 -> wr_en held, addr 77, data 3A stable for those cycles; total write takes 8 cycles.
REQ-034 sec changes 34->35 while idx=1 -> current write completes "12:34"; one cycle after IDLE, a second write "12:35".
REQ-035 Input min=8'h1A -> data for idx1 = 3F ('?'); a refresh pulse in IDLE with unchanged input -> identical 5-write sequence.
REQ-036 Reset pulsed while idx=2 -> wr_en=0 immediately; after release, a full write restarts from idx0 at addr 75.
